gbuff_host_port: RTL

Host-side port of the systolic-array global buffers. Accepts CFU commands, writes operand words into the A and B global buffers, and reads result words back out of the C buffer. It launches the compute FSM with K/M/N and reports its status. It is the opposite end of the buffer traffic from the compute-side address generator, which reads A/B and writes C.

---
 rtl/gbuff_host_port_pkg.sv | 20 ++
 rtl/gbuff_host_port.sv | 110 +++++++++++
 2 files changed

// File: rtl/gbuff_host_port_pkg.sv
// gbuff_host_port_pkg: opcodes, error codes, FSM states and C-lane select shared by the host port
package gbuff_host_port_pkg;
  localparam int DATA_W   = 32;
  localparam int C_DATA_W = 128;
  localparam int C_LANES  = C_DATA_W / DATA_W;
  localparam logic [2:0] OP_WR_A   = 3'd0;
  localparam logic [2:0] OP_WR_B   = 3'd1;
  localparam logic [2:0] OP_RD_C   = 3'd2;
  localparam logic [2:0] OP_START  = 3'd3;
  localparam logic [2:0] OP_STATUS = 3'd4;
  localparam logic [DATA_W-1:0] ERR_BUSY    = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] ERR_ILLEGAL = 32'hFFFF_FFFE;
  typedef enum logic [2:0] {ST_IDLE, ST_EXEC, ST_RD_WAIT, ST_RD_CAP, ST_RESP} state_t;
  // lane 0 is the most significant word of the C row
  function automatic logic [DATA_W-1:0] c_lane(input logic [C_DATA_W-1:0] word, input logic [1:0] lane);
    logic [C_DATA_W-1:0] s;
    s = word >> (DATA_W * (C_LANES - 1 - int'(lane)));
    return s[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/gbuff_host_port.sv
// gbuff_host_port: CFU-facing port that fills the A/B buffers, reads C lanes and starts compute
module gbuff_host_port
  import gbuff_host_port_pkg::*;
#(
  parameter int ADDR_BITS   = 16,
  parameter int DATA_BITS   = DATA_W,
  parameter int C_DATA_BITS = C_DATA_W
) (
  input  logic                   axis_clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [9:0]             cmd_function_id,
  input  logic [DATA_BITS-1:0]   cmd_inputs_0,
  input  logic [DATA_BITS-1:0]   cmd_inputs_1,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_BITS-1:0]   rsp_outputs_0,
  output logic                   A_wr_en,
  output logic                   B_wr_en,
  output logic [ADDR_BITS-1:0]   A_index,
  output logic [ADDR_BITS-1:0]   B_index,
  output logic [DATA_BITS-1:0]   A_data_in,
  output logic [DATA_BITS-1:0]   B_data_in,
  output logic [ADDR_BITS-1:0]   C_index,
  input  logic [C_DATA_BITS-1:0] C_data_out,
  input  logic                   busy,
  output logic                   in_valid,
  output logic [7:0]             K,
  output logic [7:0]             M,
  output logic [7:0]             N
);
  state_t r_state;
  logic [2:0] r_op;
  logic [DATA_BITS-1:0] r_in0, r_in1;
  logic w_legal, w_blocked, w_do_a, w_do_b, w_do_start;
  logic [DATA_BITS-1:0] w_exec_rsp;
  logic w_unused;
  assign cmd_ready = r_state == ST_IDLE;
  assign rsp_valid = r_state == ST_RESP;
  assign w_unused  = ^{cmd_function_id[9:3], r_in0[DATA_BITS-1:24]};
  // busy is sampled in EXEC; only buffer writes and START are blocked by it
  always_comb begin
    w_legal    = r_op <= OP_STATUS;
    w_blocked  = busy && (r_op == OP_WR_A || r_op == OP_WR_B || r_op == OP_START);
    w_do_a     = r_state == ST_EXEC && r_op == OP_WR_A && !busy;
    w_do_b     = r_state == ST_EXEC && r_op == OP_WR_B && !busy;
    w_do_start = r_state == ST_EXEC && r_op == OP_START && !busy;
    w_exec_rsp = !w_legal ? ERR_ILLEGAL :
                 w_blocked ? ERR_BUSY :
                 r_op == OP_STATUS ? DATA_BITS'(busy) : '0;
  end
  always_ff @(posedge axis_clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_op          <= '0;
      r_in0         <= '0;
      r_in1         <= '0;
      rsp_outputs_0 <= '0;
      A_wr_en       <= 1'b0;
      B_wr_en       <= 1'b0;
      A_index       <= '0;
      B_index       <= '0;
      A_data_in     <= '0;
      B_data_in     <= '0;
      C_index       <= '0;
      in_valid      <= 1'b0;
      K             <= '0;
      M             <= '0;
      N             <= '0;
    end else begin
      A_wr_en  <= w_do_a;
      B_wr_en  <= w_do_b;
      in_valid <= w_do_start;
      if (w_do_a) begin
        A_index   <= r_in0[ADDR_BITS-1:0];
        A_data_in <= r_in1;
      end
      if (w_do_b) begin
        B_index   <= r_in0[ADDR_BITS-1:0];
        B_data_in <= r_in1;
      end
      if (w_do_start) begin
        K <= r_in0[7:0];
        M <= r_in0[15:8];
        N <= r_in0[23:16];
      end
      case (r_state)
        ST_IDLE: if (cmd_valid) begin
          r_op    <= cmd_function_id[2:0];
          r_in0   <= cmd_inputs_0;
          r_in1   <= cmd_inputs_1;
          r_state <= cmd_function_id[2:0] == OP_RD_C ? ST_RD_WAIT : ST_EXEC;
          if (cmd_function_id[2:0] == OP_RD_C) C_index <= cmd_inputs_0[ADDR_BITS-1:0];
        end
        ST_EXEC: begin
          rsp_outputs_0 <= w_exec_rsp;
          r_state       <= ST_RESP;
        end
        ST_RD_WAIT: r_state <= ST_RD_CAP;
        ST_RD_CAP: begin
          rsp_outputs_0 <= c_lane(C_data_out, r_in1[1:0]);
          r_state       <= ST_RESP;
        end
        ST_RESP: if (rsp_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
